// File: rtl/dbg_trace_probe.sv
// rtl/dbg_trace_probe.sv - debug probe: live channel view plus triggered DEPTH-sample trace buffer
// Sequential readout of the capture memory once the trace is complete.
module dbg_trace_probe #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     CLKSYS,
  input  logic                     RST,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        test,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cap_sel_q, cap_sel_d;
  logic [DATA_W-1:0] cap_mask_q, cap_mask_d;
  logic [DATA_W-1:0] cap_value_q, cap_value_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] test_q, test_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] live_sample;
  logic [DATA_W-1:0] cap_sample;
  logic              cap_sel_ok;
  logic              trigger;

  // Out-of-range selects read as zero and leave cap_sel_ok low.
  always_comb begin
    live_sample = '0;
    cap_sample  = '0;
    cap_sel_ok  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(sel) == k) live_sample = ch_data[k*DATA_W +: DATA_W];
      if (32'(cap_sel_q) == k) begin
        cap_sample = ch_data[k*DATA_W +: DATA_W];
        cap_sel_ok = 1'b1;
      end
    end
  end

  assign trigger = cap_sel_ok && (((cap_sample ^ cap_value_q) & cap_mask_q) == '0);

  always_comb begin
    state_d     = state_q;
    cap_sel_d   = cap_sel_q;
    cap_mask_d  = cap_mask_q;
    cap_value_d = cap_value_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    test_d      = live_sample;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = cap_sample;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d     = ARMED;
          cap_sel_d   = sel;
          cap_mask_d  = trig_mask;
          cap_value_d = trig_value;
          count_d     = '0;
          rd_ptr_d    = '0;
        end else if (state_q == DONE && rd_en && rd_ptr_q < CNT_W'(DEPTH)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end
      ARMED: begin
        if (trigger) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          count_d   = CNT_W'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        mem_we    = 1'b1;
        mem_waddr = count_q[AW-1:0];
        count_d   = count_q + 1'b1;
        if (count_q == CNT_W'(DEPTH - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKSYS) begin
    if (!RST) begin
      state_q     <= IDLE;
      cap_sel_q   <= '0;
      cap_mask_q  <= '0;
      cap_value_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      test_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_sel_q   <= cap_sel_d;
      cap_mask_q  <= cap_mask_d;
      cap_value_q <= cap_value_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      test_q      <= test_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Trace memory keeps its contents across reset.
  always_ff @(posedge CLKSYS) begin
    if (RST && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign test     = test_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign count    = count_q;

endmodule
